// File: rtl/fetch_aligner.sv
// Realigns word-aligned fetch data into 16/32-bit instructions through a 4-parcel buffer.
// Compressed (RVC) support is enabled by defining FETCH_ALIGNER_RVC_EN; otherwise RV32I only.
module fetch_aligner #(
  parameter int          INSTRUCTION_WIDTH = 32,
  parameter logic [31:0] RESET_PC          = 32'h0000_0000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         redirect_i,
  input  logic [31:0]                  redirect_pc_i,
  output logic [31:0]                  fetch_addr_o,
  input  logic                         fetch_valid_i,
  output logic                         fetch_ready_o,
  input  logic [INSTRUCTION_WIDTH-1:0] fetch_data_i,
  output logic                         instr_valid_o,
  input  logic                         instr_ready_i,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_o,
  output logic [31:0]                  instr_pc_o,
  output logic                         instr_compressed_o,
  output logic [2:0]                   dbg_count_o
);

  // Handshakes: a fetch word transfers on fetch_valid_i && fetch_ready_o, an instruction
  // on instr_valid_o && instr_ready_i; neither transfers while redirect_i is high.

  localparam int PW = INSTRUCTION_WIDTH / 2;
`ifdef FETCH_ALIGNER_RVC_EN
  localparam bit RVC = 1'b1;
`else
  localparam bit RVC = 1'b0;
`endif
  localparam logic [31:0] PC_MASK = RVC ? 32'hFFFF_FFFE : 32'hFFFF_FFFC;

  logic [PW-1:0] parcel_q [4];
  logic [PW-1:0] parcel_d [4];
  logic [PW-1:0] push_p   [2];
  logic [2:0]    count_q, count_d;
  logic [31:0]   pc_q, addr_q;
  logic          drop_half_q;

  logic          head_is_32, avail, pop_fire, push_fire;
  logic [2:0]    pop_n, push_n, keep, src, slot;
  logic          unused_pc_bit;

  assign unused_pc_bit = redirect_pc_i[0];

  // Without RVC every instruction is two parcels regardless of its low bits.
  assign head_is_32 = !RVC || (parcel_q[0][1:0] == 2'b11);
  assign avail      = head_is_32 ? (count_q >= 3'd2) : (count_q >= 3'd1);

  assign instr_valid_o      = avail && !redirect_i;
  assign instr_compressed_o = instr_valid_o && !head_is_32;
  assign instruction_o      = !instr_valid_o ? '0 :
                              head_is_32 ? {parcel_q[1], parcel_q[0]} : {{PW{1'b0}}, parcel_q[0]};
  assign instr_pc_o         = pc_q;
  assign fetch_ready_o      = (count_q <= 3'd2) && !redirect_i;
  assign fetch_addr_o       = addr_q;
  assign dbg_count_o        = count_q;

  assign pop_fire  = instr_valid_o && instr_ready_i;
  assign push_fire = fetch_valid_i && fetch_ready_o;
  assign pop_n     = pop_fire ? (head_is_32 ? 3'd2 : 3'd1) : 3'd0;
  assign push_n    = push_fire ? (drop_half_q ? 3'd1 : 3'd2) : 3'd0;
  assign keep      = count_q - pop_n;
  assign count_d   = keep + push_n;

  always_comb begin
    push_p[0] = drop_half_q ? fetch_data_i[INSTRUCTION_WIDTH-1:PW] : fetch_data_i[PW-1:0];
    push_p[1] = fetch_data_i[INSTRUCTION_WIDTH-1:PW];
    src  = '0;
    slot = '0;
    for (int i = 0; i < 4; i++) begin
      parcel_d[i] = parcel_q[i];
      src  = 3'(i) + pop_n;
      slot = 3'(i) - keep;
      // Survivors shift down by the pop amount; new parcels land right after them.
      if (3'(i) < keep) begin
        parcel_d[i] = parcel_q[src[1:0]];
      end else if (slot < push_n) begin
        parcel_d[i] = push_p[slot[0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      pc_q        <= RESET_PC & PC_MASK;
      addr_q      <= {RESET_PC[31:2], 2'b00};
      drop_half_q <= RVC && RESET_PC[1];
      for (int i = 0; i < 4; i++) parcel_q[i] <= '0;
    end else if (redirect_i) begin
      count_q     <= '0;
      pc_q        <= redirect_pc_i & PC_MASK;
      addr_q      <= {redirect_pc_i[31:2], 2'b00};
      drop_half_q <= RVC && redirect_pc_i[1];
    end else begin
      count_q  <= count_d;
      parcel_q <= parcel_d;
      pc_q     <= pc_q + {28'd0, pop_n, 1'b0};
      if (push_fire) begin
        addr_q      <= addr_q + 32'd4;
        drop_half_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_aligner.sv
// Directed bench for fetch_aligner; expectations follow the build's FETCH_ALIGNER_RVC_EN setting.
module tb_fetch_aligner;

  logic        clk;
  logic        rst_n;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] fetch_addr_o;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_data_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] instr_pc_o;
  logic        instr_compressed_o;
  logic [2:0]  dbg_count_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  logic [31:0] words [4];

  fetch_aligner #(.INSTRUCTION_WIDTH(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fetch_addr_o(fetch_addr_o), .fetch_valid_i(fetch_valid_i),
    .fetch_ready_o(fetch_ready_o), .fetch_data_i(fetch_data_i),
    .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
    .instruction_o(instruction_o), .instr_pc_o(instr_pc_o),
    .instr_compressed_o(instr_compressed_o), .dbg_count_o(dbg_count_o)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    fetch_valid_i = 1'b0;
    step();
    redirect_i    = 1'b0;
  endtask

  initial begin
    int widx;
    bit acc;
    rst_n = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
    fetch_valid_i = 1'b0; fetch_data_i = '0; instr_ready_i = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    #1;

    // Reset, idle
    check("rst_fetch_addr", fetch_addr_o, 32'h100);
    check("rst_fetch_ready", {31'd0, fetch_ready_o}, 32'd1);
    check("rst_instr_valid", {31'd0, instr_valid_o}, 32'd0);
    check("rst_count", {29'd0, dbg_count_o}, 32'd0);
    check("rst_pc", instr_pc_o, 32'h100);
    check("rst_instruction", instruction_o, 32'h0);
    check("rst_compressed", {31'd0, instr_compressed_o}, 32'd0);
    step();

    // Aligned 32-bit stream
    do_redirect(32'h0);
    instr_ready_i = 1'b1; fetch_valid_i = 1'b1; fetch_data_i = 32'h00500093; #1;
    check("al_ready0", {31'd0, fetch_ready_o}, 32'd1);
    step();
    fetch_data_i = 32'h00A00113; #1;
    check("al_instr0", instruction_o, 32'h00500093);
    check("al_pc0", instr_pc_o, 32'h0);
    check("al_c0", {31'd0, instr_compressed_o}, 32'd0);
    check("al_ready1", {31'd0, fetch_ready_o}, 32'd1);
    step();
    fetch_valid_i = 1'b0; #1;
    check("al_valid1", {31'd0, instr_valid_o}, 32'd1);
    check("al_instr1", instruction_o, 32'h00A00113);
    check("al_pc1", instr_pc_o, 32'h4);
    step();
    check("al_empty", {31'd0, instr_valid_o}, 32'd0);

    // Two compressed in one word
    do_redirect(32'h0);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h45014505;
    step();
    fetch_valid_i = 1'b0; #1;
`ifdef FETCH_ALIGNER_RVC_EN
    check("c2_instr0", instruction_o, 32'h00004505);
    check("c2_pc0", instr_pc_o, 32'h0);
    check("c2_c0", {31'd0, instr_compressed_o}, 32'd1);
    step();
    check("c2_instr1", instruction_o, 32'h00004501);
    check("c2_pc1", instr_pc_o, 32'h2);
    check("c2_c1", {31'd0, instr_compressed_o}, 32'd1);
`else
    check("c2_instr0", instruction_o, 32'h45014505);
    check("c2_pc0", instr_pc_o, 32'h0);
    check("c2_c0", {31'd0, instr_compressed_o}, 32'd0);
`endif
    step();
    check("c2_empty", {31'd0, instr_valid_o}, 32'd0);

    // Straddling 32-bit
    do_redirect(32'h0);
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00934505;
    step();
    fetch_data_i = 32'hFFFF0050; #1;
`ifdef FETCH_ALIGNER_RVC_EN
    check("st_instr0", instruction_o, 32'h00004505);
    check("st_c0", {31'd0, instr_compressed_o}, 32'd1);
    step();
    fetch_valid_i = 1'b0; #1;
    check("st_instr1", instruction_o, 32'h00500093);
    check("st_pc1", instr_pc_o, 32'h2);
    check("st_c1", {31'd0, instr_compressed_o}, 32'd0);
    check("st_count1", {29'd0, dbg_count_o}, 32'd3);
    step();
    check("st_half_left", {31'd0, instr_valid_o}, 32'd0);
    check("st_count2", {29'd0, dbg_count_o}, 32'd1);
`else
    check("st_instr0", instruction_o, 32'h00934505);
    check("st_c0", {31'd0, instr_compressed_o}, 32'd0);
    step();
    fetch_valid_i = 1'b0; #1;
    check("st_instr1", instruction_o, 32'hFFFF0050);
    check("st_pc1", instr_pc_o, 32'h4);
`endif

    // Redirect mid-stream
    do_redirect(32'h0);
`ifdef FETCH_ALIGNER_RVC_EN
    fetch_valid_i = 1'b1; fetch_data_i = 32'h45014505;
    step();
    step();
    fetch_valid_i = 1'b0; #1;
    check("rd_count_before", {29'd0, dbg_count_o}, 32'd3);
`else
    instr_ready_i = 1'b0;
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00500093;
    step();
    fetch_data_i = 32'h00A00113;
    step();
    fetch_valid_i = 1'b0; #1;
    check("rd_count_before", {29'd0, dbg_count_o}, 32'd4);
    check("rd_full_ready", {31'd0, fetch_ready_o}, 32'd0);
`endif
    redirect_i = 1'b1; redirect_pc_i = 32'h102; #1;
    check("rd_valid_during", {31'd0, instr_valid_o}, 32'd0);
    check("rd_ready_during", {31'd0, fetch_ready_o}, 32'd0);
    step();
    redirect_i = 1'b0; #1;
    check("rd_count_after", {29'd0, dbg_count_o}, 32'd0);
    check("rd_fetch_addr", fetch_addr_o, 32'h100);
    instr_ready_i = 1'b0; fetch_valid_i = 1'b1; fetch_data_i = 32'h4505FFFF;
    step();
    fetch_valid_i = 1'b0; #1;
    check("rd_fetch_addr_next", fetch_addr_o, 32'h104);
`ifdef FETCH_ALIGNER_RVC_EN
    check("rd_instr", instruction_o, 32'h00004505);
    check("rd_pc", instr_pc_o, 32'h102);
    check("rd_c", {31'd0, instr_compressed_o}, 32'd1);
    check("rd_count_dropped", {29'd0, dbg_count_o}, 32'd1);
`else
    check("rd_instr", instruction_o, 32'h4505FFFF);
    check("rd_pc", instr_pc_o, 32'h100);
    check("rd_c", {31'd0, instr_compressed_o}, 32'd0);
`endif

    // Backpressure with a scoreboard
    do_redirect(32'h0);
    words[0] = 32'h00500093; words[1] = 32'h00A00113;
    words[2] = 32'h00F00193; words[3] = 32'h01400213;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(words[i]);
      exp_pc_q.push_back(32'(i * 4));
    end
    widx = 0;
    for (int cyc = 0; cyc < 20 && exp_q.size() > 0; cyc++) begin
      instr_ready_i = (cyc >= 5);
      fetch_valid_i = (widx < 4);
      fetch_data_i  = words[widx[1:0]];
      #1;
      if (cyc >= 2 && cyc <= 4) begin
        check("bp_count", {29'd0, dbg_count_o}, 32'd4);
        check("bp_fetch_ready", {31'd0, fetch_ready_o}, 32'd0);
        check("bp_instr_hold", instruction_o, 32'h00500093);
        check("bp_pc_hold", instr_pc_o, 32'h0);
      end
      if (instr_valid_o && instr_ready_i) begin
        check("bp_sb_instr", instruction_o, exp_q.pop_front());
        check("bp_sb_pc", instr_pc_o, exp_pc_q.pop_front());
      end
      acc = fetch_valid_i && fetch_ready_o;
      step();
      if (acc) widx++;
    end
    check("bp_all_consumed", 32'(exp_q.size()), 32'd0);
    fetch_valid_i = 1'b0; instr_ready_i = 1'b0;

    // Reset asserted mid-stream
    fetch_valid_i = 1'b1; fetch_data_i = 32'h00500093;
    step();
    fetch_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_count", {29'd0, dbg_count_o}, 32'd0);
    check("mr_valid", {31'd0, instr_valid_o}, 32'd0);
    check("mr_fetch_addr", fetch_addr_o, 32'h100);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_aligner.md
# fetch_aligner

- Sits between instruction memory and the compressed-instruction expander.
- Accepts word-aligned 32-bit fetch data and buffers it as 16-bit parcels.
- Each cycle it presents one instruction on `instruction`, low-justified, with its PC: either a 16-bit RVC parcel zero-extended, or a full 32-bit instruction that may straddle a word boundary.
- It also handles control-flow redirects to half-word-aligned targets.

## Interface
- `INSTRUCTION_WIDTH`, default 32: width of fetch words and output instruction.
- `RESET_PC`, default 32'h0000_0000: PC after reset; bit 0 ignored.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `redirect_i` input 1: flush and restart fetch at `redirect_pc_i`.
- `redirect_pc_i` input 32: redirect target; bit 0 ignored.
- `fetch_addr_o` output 32: word address of the next word expected, bits [1:0] = 00.
- `fetch_valid_i` input 1: `fetch_data_i` holds the word at `fetch_addr_o`.
- `fetch_ready_o` output 1: the word is accepted when valid && ready.
- `fetch_data_i` input 32: memory word, little-endian parcels (parcel at addr+0 is [15:0]).
- `instr_valid_o` output 1: a complete instruction is presented.
- `instr_ready_i` input 1: downstream consumes it when valid && ready.
- `instruction_o` output 32: the instruction; [31:16] = 0 when compressed.
- `instr_pc_o` output 32: PC of the presented instruction.
- `instr_compressed_o` output 1: the presented instruction is 16-bit (parcel[1:0] != 2'b11).

## Operation
- **Buffer.** 4-entry halfword FIFO (`buf[0..3]`) plus a 3-bit `count` (0..4). `buf[0]` is the oldest parcel.
- **Accepting fetch data.**
  - `fetch_ready_o` = (`count` <= 2) && !`redirect_i`. It is a function of registered state and `redirect_i` only, never of `instr_ready_i`.
  - On an accepted word, push [15:0] then [31:16].
  - If `drop_half` is set, push only [31:16] and clear `drop_half`.
  - `fetch_addr_o` advances by 4 on every accepted word.
- **Presenting an instruction.**
  - If `count` >= 1 and `buf[0]`[1:0] != 2'b11: `instr_valid_o` = 1, `instruction_o` = {16'h0, `buf[0]`}.
  - If `count` >= 2 and `buf[0]`[1:0] == 2'b11: `instr_valid_o` = 1, `instruction_o` = {`buf[1]`, `buf[0]`}.
  - Any other case: `instr_valid_o` = 0.
  - `instr_valid_o` is forced to 0 while `redirect_i` = 1.
- **Consuming an instruction.** On valid && ready, pop 1 parcel (compressed) or 2 parcels (32-bit). `instr_pc_o` advances by 2 or 4.
- **Simultaneous push and pop.** `count_next` = `count` + pushed − popped. Surviving parcels shift toward `buf[0]`; pushed parcels append after them.
- **Redirect** (`redirect_i` = 1) has priority over everything:
  - no handshake completes that cycle;
  - `count` <= 0;
  - `instr_pc_o` <= {`redirect_pc_i`[31:1], 1'b0};
  - `fetch_addr_o` <= {`redirect_pc_i`[31:2], 2'b00};
  - `drop_half` <= `redirect_pc_i`[1].
  - Any data arriving for the old stream after the flush is the fetch unit's responsibility; the aligner treats the next accepted word as the target word.
- **Reset values.**
  - `count` = 0.
  - `instr_pc_o` = {`RESET_PC`[31:1], 0}; `fetch_addr_o` = {`RESET_PC`[31:2], 00}; `drop_half` = `RESET_PC`[1].
  - `instr_valid_o` = 0, `instruction_o` = 0, `instr_compressed_o` = 0; `fetch_ready_o` = 1 after reset release.
- **Instruction length.** Only the 16/32-bit encodings are recognised. Encodings with [4:2] = 111 are treated as 32-bit.

## Timing
- A word accepted in cycle N is visible on the instr outputs in cycle N+1: 1-cycle latency, outputs decoded combinationally from registered `buf`.
- Sustained throughput is one word per cycle when `instr_ready_i` = 1:
  - at steady `count` = 2, pop 2 + push 2 keeps `count` at 2;
  - a run of compressed instructions stalls fetch once `count` reaches 3.
- A 32-bit instruction straddling a word boundary is presented in the cycle after its second half is accepted.
- With `instr_valid_o` = 1 and `instr_ready_i` = 0:
  - `instruction_o`, `instr_pc_o` and `instr_compressed_o` stay stable;
  - pushes may still occur up to `count` = 4.
- At `count` = 4, `fetch_ready_o` = 0 until a pop.
- Reset asserted mid-stream clears all state immediately.

## Configuration
- `FETCH_ALIGNER_RVC_EN` defined:
  - full RVC support as above.
- `FETCH_ALIGNER_RVC_EN` undefined (RV32I only):
  - `instr_compressed_o` tied 0;
  - every instruction needs 2 parcels;
  - `redirect_pc_i`[1], `RESET_PC`[1] and `drop_half` are ignored (forced 0);
  - PC always steps by 4.

## Test plan
- **Reset, idle:** release `rst_n` with `RESET_PC` = 0x100 → `fetch_addr_o` = 0x100, `fetch_ready_o` = 1, `instr_valid_o` = 0, `count` = 0.
- **Aligned 32-bit stream:** words 0x00500093, 0x00A00113 back-to-back, `instr_ready_i` = 1 → instructions output at pc 0x0 and 0x4 on consecutive cycles, `fetch_ready_o` never drops.
- **Two compressed in one word:** word 0x45014505 → `instruction_o` 0x00004505 at pc 0x0 with compressed = 1, then 0x00004501 at pc 0x2.
- **Straddling 32-bit:** words 0x00934505 then 0xFFFF0050 → 0x00004505 at pc 0x0, then 0x00500093 at pc 0x2 with compressed = 0.
- **Redirect mid-stream:** `count` = 3, redirect to 0x102 → `count` = 0, `fetch_addr_o` = 0x100; next word 0x4505FFFF → 0x00004505 at pc 0x102, parcel 0xFFFF discarded.
- **Backpressure:** `instr_ready_i` = 0 for 5 cycles while fetch is valid → `count` saturates at 4, `fetch_ready_o` = 0, instr outputs unchanged; on release, the stream resumes with no parcel lost.
